// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce/edge-detect front end.
package debounce_pkg;

  // Debounce FSM states; q is high in ST_HI and WAIT_LO.
  typedef enum logic [1:0] {
    ST_LO   = 2'b00,
    WAIT_HI = 2'b01,
    ST_HI   = 2'b10,
    WAIT_LO = 2'b11
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Plain flop synchronizer for an asynchronous single-bit input.
// No logic between stages; all stages clear to 0 on reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_async,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain, one stage per clock.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronize a raw button/switch input, debounce it with a counter FSM,
// and present a clean registered level plus one-cycle rise/fall strobes.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_async,
  input  logic d_in,
  output logic q,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_out;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .reset_async (reset_async),
    .d           (d_in),
    .q           (sync_out)
  );

  // Debounce FSM: accept a change only after DEBOUNCE_CYCLES consecutive
  // synchronized samples at the new level; strobes are registered alongside q.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state_q    <= ST_LO;
      cnt_q      <= '0;
      q          <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state_q)
        ST_LO: begin
          q <= 1'b0;
          if (sync_out) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_HI: begin
          if (!sync_out) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_HI;
            q          <= 1'b1;
            rise_pulse <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HI: begin
          q <= 1'b1;
          if (!sync_out) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_LO: begin
          if (sync_out) begin
            state_q <= ST_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_LO;
            q          <= 1'b0;
            fall_pulse <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_LO;
          q       <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
